// File: rtl/lsu_mmreg_target.sv
// Memory-mapped 64-bit register window answering LSU loads/stores with tagged responses.
// Optional macro RV_MMREG_BYTE_WRITE_EN enables byte-masked stores; otherwise stores must be full dword.
module lsu_mmreg_target #(
    parameter int          NUM_REGS  = 16,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_F00C_0000
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [63:0]              req_addr,
    input  logic [63:0]              req_wdata,
    input  logic [7:0]               req_bytemask,
    input  logic [2:0]               req_tag,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [63:0]              rsp_rdata,
    output logic                     rsp_error,
    output logic [2:0]               rsp_tag,
    output logic [NUM_REGS*64-1:0]   reg_q
);

    localparam int          IDX_W     = $clog2(NUM_REGS);
    localparam logic [63:0] WIN_BYTES = 64'(NUM_REGS) * 64'd8;

    logic        s1_valid;
    logic        s1_write;
    logic [63:0] s1_addr;
    logic [63:0] s1_wdata;
    logic [7:0]  s1_bytemask;
    logic [2:0]  s1_tag;

    logic [63:0] regs [NUM_REGS];

    logic [63:0]      offset;
    logic             in_range;
    logic             misaligned;
    logic             wmask_error;
    logic             s1_error;
    logic [IDX_W-1:0] idx;
    logic [63:0]      rd_word;
    logic [63:0]      bit_mask;
    logic [63:0]      wr_word;
    logic             do_write;
    logic             accept;

    // Response entry layout: {rdata, error, tag}; entry 0 is the head.
    logic [67:0] fifo_q [3];
    logic [67:0] fifo_d [3];
    logic [1:0]  fifo_count;
    logic [1:0]  count_d;
    logic        pop;
    logic [67:0] push_entry;

    assign req_ready = rst_l & (({1'b0, fifo_count} + {2'b00, s1_valid}) < 3'd3);
    assign accept    = req_valid & req_ready;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            s1_valid    <= 1'b0;
            s1_write    <= 1'b0;
            s1_addr     <= '0;
            s1_wdata    <= '0;
            s1_bytemask <= '0;
            s1_tag      <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_write    <= req_write;
                s1_addr     <= req_addr;
                s1_wdata    <= req_wdata;
                s1_bytemask <= req_bytemask;
                s1_tag      <= req_tag;
            end
        end
    end

    always_comb begin
        offset     = s1_addr - BASE_ADDR;
        in_range   = (s1_addr >= BASE_ADDR) && (offset < WIN_BYTES);
        misaligned = |s1_addr[2:0];
        idx        = offset[IDX_W+2:3];
        rd_word    = in_range ? regs[idx] : 64'd0;
        for (int b = 0; b < 8; b++) begin
            bit_mask[8*b +: 8] = {8{s1_bytemask[b]}};
        end
`ifdef RV_MMREG_BYTE_WRITE_EN
        wmask_error = 1'b0;
        wr_word     = (rd_word & ~bit_mask) | (s1_wdata & bit_mask);
`else
        wmask_error = s1_write & (s1_bytemask != 8'hFF);
        wr_word     = s1_wdata & bit_mask;
`endif
        s1_error   = ~in_range | misaligned | wmask_error;
        do_write   = s1_valid & s1_write & ~s1_error;
        push_entry = {((s1_write | s1_error) ? 64'd0 : rd_word), s1_error, s1_tag};
    end

    // A write sitting in S1 on a reset edge is dropped because reset takes priority.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (do_write) begin
            regs[idx] <= wr_word;
        end
    end

    // Shift-style queue: vacated slots are zeroed so an empty head reads as zero.
    always_comb begin
        pop     = (fifo_count != 2'd0) & rsp_ready;
        fifo_d  = fifo_q;
        count_d = fifo_count;
        if (pop) begin
            fifo_d[0] = fifo_q[1];
            fifo_d[1] = fifo_q[2];
            fifo_d[2] = '0;
            count_d   = fifo_count - 2'd1;
        end
        if (s1_valid) begin
            fifo_d[count_d] = push_entry;
            count_d         = count_d + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            fifo_count <= '0;
            for (int i = 0; i < 3; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            fifo_count <= count_d;
            fifo_q     <= fifo_d;
        end
    end

    assign rsp_valid = (fifo_count != 2'd0);
    assign rsp_rdata = fifo_q[0][67:4];
    assign rsp_error = fifo_q[0][3];
    assign rsp_tag   = fifo_q[0][2:0];

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[i*64 +: 64] = regs[i];
        end
    end

endmodule

// File: tb/tb_lsu_mmreg_target.sv
// Randomized and directed bench for lsu_mmreg_target against a transaction-level model
// (register array plus response queue), covering both RV_MMREG_BYTE_WRITE_EN builds.
module tb_lsu_mmreg_target;

    localparam int          NUM_REGS = 16;
    localparam logic [63:0] BASE     = 64'h0000_0000_F00C_0000;
    localparam logic [63:0] WIN      = 64'(NUM_REGS) * 64'd8;

    logic                   clk;
    logic                   rst_l;
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic [63:0]            req_addr;
    logic [63:0]            req_wdata;
    logic [7:0]             req_bytemask;
    logic [2:0]             req_tag;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [63:0]            rsp_rdata;
    logic                   rsp_error;
    logic [2:0]             rsp_tag;
    logic [NUM_REGS*64-1:0] reg_q;

    lsu_mmreg_target #(.NUM_REGS(NUM_REGS), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_l(rst_l),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_bytemask(req_bytemask),
        .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .rsp_tag(rsp_tag), .reg_q(reg_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] rdata;
        logic        error;
        logic [2:0]  tag;
    } rsp_t;

    typedef struct packed {
        logic        write;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  mask;
        logic [2:0]  tag;
    } req_t;

    // Model: register contents, one request in flight before its response exists, and the queue.
    logic [63:0] m_regs [NUM_REGS];
    rsp_t        m_queue [$];
    bit          m_inflight;
    req_t        m_req;
    bit          last_accept;

    logic [2:0]  dut_tags [$];
    int          vectors     = 0;
    int          checks      = 0;
    int          miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit access_error(input req_t r);
        bit bad;
        bad = (r.addr < BASE) || (r.addr >= BASE + WIN) || (r.addr % 8 != 0);
`ifndef RV_MMREG_BYTE_WRITE_EN
        if (r.write && r.mask != 8'hFF) bad = 1'b1;
`endif
        return bad;
    endfunction

    function automatic bit model_ready();
        return rst_l && ((m_queue.size() + int'(m_inflight)) < 3);
    endfunction

    task automatic checkOutput();
        check("req_ready", 64'(req_ready), 64'(model_ready()));
        check("rsp_valid", 64'(rsp_valid), 64'(m_queue.size() > 0));
        if (m_queue.size() > 0) begin
            check("rsp_rdata", rsp_rdata, m_queue[0].rdata);
            check("rsp_error", 64'(rsp_error), 64'(m_queue[0].error));
            check("rsp_tag", 64'(rsp_tag), 64'(m_queue[0].tag));
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            check($sformatf("reg_q[%0d]", i), reg_q[i*64 +: 64], m_regs[i]);
        end
        if (rsp_valid && rsp_ready) dut_tags.push_back(rsp_tag);
    endtask

    // Advance the model across the coming clock edge using the inputs now being driven.
    task automatic modelStep();
        bit   acc;
        bit   err;
        int   idx;
        rsp_t r;
        if (!rst_l) begin
            for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
            m_queue.delete();
            m_inflight  = 0;
            last_accept = 0;
            return;
        end
        acc = req_valid && model_ready();
        if (m_queue.size() > 0 && rsp_ready) void'(m_queue.pop_front());
        if (m_inflight) begin
            err = access_error(m_req);
            idx = int'((m_req.addr - BASE) / 8);
            r.rdata = (!m_req.write && !err) ? m_regs[idx] : 64'd0;
            r.error = err;
            r.tag   = m_req.tag;
            if (m_req.write && !err) begin
                for (int b = 0; b < 8; b++) begin
                    if (m_req.mask[b]) m_regs[idx][8*b +: 8] = m_req.wdata[8*b +: 8];
                end
            end
            m_queue.push_back(r);
        end
        m_inflight  = acc;
        m_req       = '{write: req_write, addr: req_addr, wdata: req_wdata,
                        mask: req_bytemask, tag: req_tag};
        last_accept = acc;
    endtask

    task automatic applyStimulus(input logic v, input logic w, input logic [63:0] a,
                                 input logic [63:0] d, input logic [7:0] m,
                                 input logic [2:0] t, input logic rr, input logic rst);
        @(posedge clk);
        #1;
        req_valid    = v;
        req_write    = w;
        req_addr     = a;
        req_wdata    = d;
        req_bytemask = m;
        req_tag      = t;
        rsp_ready    = rr;
        rst_l        = rst;
        vectors++;
        @(negedge clk);
        checkOutput();
        modelStep();
    endtask

    task automatic idle(input logic rr);
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 8'h00, 3'd0, rr, 1'b1);
    endtask

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        case ($urandom_range(0, 5))
            0, 1, 2: a = BASE + 64'(8 * $urandom_range(0, NUM_REGS - 1));
            3:       a = BASE + 64'(8 * $urandom_range(0, NUM_REGS - 1)) + 64'($urandom_range(1, 7));
            4:       a = $urandom_range(0, 1) ? BASE + WIN + 64'(8 * $urandom_range(0, 3))
                                              : BASE - 64'(8 * $urandom_range(1, 4));
            default: a = {$urandom, $urandom};
        endcase
        return a;
    endfunction

    initial begin
        int t;
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
        m_inflight   = 0;
        last_accept  = 0;
        rst_l        = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_bytemask = '0;
        req_tag      = '0;
        rsp_ready    = 1'b1;

        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 8'h00, 3'd0, 1'b1, 1'b0);
        check("ready_in_reset", 64'(req_ready), 64'd0);
        idle(1'b1);
        check("ready_after_release", 64'(req_ready), 64'd1);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_rdata", rsp_rdata, 64'd0);
        check("reset_rsp_error", 64'(rsp_error), 64'd0);
        check("reset_rsp_tag", 64'(rsp_tag), 64'd0);
        check("reset_reg_q_zero", 64'(|reg_q), 64'd0);

        // Store then back-to-back load of the same register.
        applyStimulus(1'b1, 1'b1, BASE + 64'h18, 64'hDEAD_BEEF_0123_4567, 8'hFF, 3'd1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, BASE + 64'h18, 64'd0, 8'h00, 3'd2, 1'b1, 1'b1);
        idle(1'b1);
        check("store_rsp_valid", 64'(rsp_valid), 64'd1);
        check("store_rsp_tag", 64'(rsp_tag), 64'd1);
        check("store_rsp_error", 64'(rsp_error), 64'd0);
        check("store_rsp_rdata", rsp_rdata, 64'd0);
        check("store_reg3", reg_q[255:192], 64'hDEAD_BEEF_0123_4567);
        idle(1'b1);
        check("load_rsp_tag", 64'(rsp_tag), 64'd2);
        check("load_rsp_rdata", rsp_rdata, 64'hDEAD_BEEF_0123_4567);

        // Misaligned and just-past-window loads.
        applyStimulus(1'b1, 1'b0, BASE + 64'h1C, 64'd0, 8'h00, 3'd3, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, BASE + WIN, 64'd0, 8'h00, 3'd4, 1'b1, 1'b1);
        idle(1'b1);
        check("misaligned_error", 64'(rsp_error), 64'd1);
        check("misaligned_rdata", rsp_rdata, 64'd0);
        idle(1'b1);
        check("range_tag", 64'(rsp_tag), 64'd4);
        check("range_error", 64'(rsp_error), 64'd1);
        check("range_rdata", rsp_rdata, 64'd0);
        check("errors_keep_reg3", reg_q[255:192], 64'hDEAD_BEEF_0123_4567);

        // Partial byte mask store to reg 2.
        applyStimulus(1'b1, 1'b1, BASE + 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 3'd5, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);
`ifdef RV_MMREG_BYTE_WRITE_EN
        check("mask_error", 64'(rsp_error), 64'd0);
        check("mask_reg2", reg_q[191:128], 64'h0000_0000_FFFF_FFFF);
`else
        check("mask_error", 64'(rsp_error), 64'd1);
        check("mask_reg2", reg_q[191:128], 64'd0);
`endif
        idle(1'b1);

        // Backpressure: five loads with the response side stalled, then released.
        dut_tags.delete();
        t = 0;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b1, 1'b0, BASE + 64'(8 * t), 64'd0, 8'h00, 3'(t), 1'b0, 1'b1);
            if (last_accept) t++;
        end
        check("stall_accepted", 64'(t), 64'd3);
        check("stall_ready_low", 64'(req_ready), 64'd0);
        for (int c = 0; c < 20 && t < 5; c++) begin
            applyStimulus(1'b1, 1'b0, BASE + 64'(8 * t), 64'd0, 8'h00, 3'(t), 1'b1, 1'b1);
            if (last_accept) t++;
        end
        check("stall_all_accepted", 64'(t), 64'd5);
        for (int c = 0; c < 6; c++) idle(1'b1);
        check("drain_count", 64'(dut_tags.size()), 64'd5);
        for (int i = 0; i < 5 && i < dut_tags.size(); i++) begin
            check($sformatf("drain_tag%0d", i), 64'(dut_tags[i]), 64'(i));
        end

        // Sustained loads with responses always consumed.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, BASE + 64'(8 * i), 64'd0, 8'h00, 3'(i % 8), 1'b1, 1'b1);
            check("sustain_ready", 64'(req_ready), 64'd1);
            if (i >= 2) begin
                check("sustain_rsp_valid", 64'(rsp_valid), 64'd1);
                check("sustain_rsp_tag", 64'(rsp_tag), 64'((i - 2) % 8));
            end
        end
        idle(1'b1);
        idle(1'b1);

        // Reset with queue and S1 occupied, including a pending store.
        applyStimulus(1'b1, 1'b0, BASE, 64'd0, 8'h00, 3'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, BASE + 64'h8, 64'd0, 8'h00, 3'd1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, BASE + 64'h28, 64'h1234_5678_9ABC_DEF0, 8'hFF, 3'd2, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 8'h00, 3'd0, 1'b0, 1'b0);
        check("midreset_ready_low", 64'(req_ready), 64'd0);
        idle(1'b1);
        check("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midreset_reg5", reg_q[383:320], 64'd0);
        check("midreset_reg_q_zero", 64'(|reg_q), 64'd0);
        check("midreset_ready_high", 64'(req_ready), 64'd1);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] m;
            m = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            applyStimulus(($urandom_range(0, 9) < 7), 1'($urandom), rand_addr(),
                          {$urandom, $urandom}, m, 3'($urandom),
                          ($urandom_range(0, 9) < 7), ($urandom_range(0, 199) != 0));
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
